regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 124 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer that sweeps a register file read port over [FIRST_REG, LAST_REG]
// and streams each captured word out as an (index, data) beat on a valid/ready handshake.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG  = 0,
    parameter int unsigned LAST_REG   = 31,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [4:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_index,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    if (LAST_REG < FIRST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dump_reader: register range must satisfy FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

    state_e                state_q, state_d;
    logic [4:0]            cur_q, cur_d;
    logic                  out_valid_q, out_valid_d;
    logic [4:0]            out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (abort && state_q != StIdle) begin
            // Cancelling drops any pending beat, even one being accepted on this edge.
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cur_d       = FirstIdx;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_d   = FirstIdx;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    out_data_d  = rd_data;
                    out_index_d = cur_q;
                    out_last_d  = (cur_q == LastIdx);
                    out_valid_d = 1'b1;
                    state_d     = StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            state_d = StDone;
                        end else begin
                            cur_d   = cur_q + 5'd1;
                            state_d = StFetch;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_q       <= FirstIdx;
            out_valid_q <= 1'b0;
            out_index_q <= 5'd0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a bench-owned register array feeds the read port,
// and every streamed beat is checked against the array contents at the moment it was fetched.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [4:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
    logic [4:0]  rd_addr1, out_index1;
    logic [31:0] rd_data1, out_data1;
    logic        out_valid1, out_last1, busy1, done1;

    logic [31:0] regs [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rd_data  = regs[rd_addr];
    assign rd_data1 = regs[rd_addr1];

    regfile_dump_reader u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .DATA_WIDTH(32)) u_one (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(ready1), .out_index(out_index1),
        .out_data(out_data1), .out_last(out_last1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A50000 + 32'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready tied high; 1: ready 1-0-0-1; 2: random ready, stray starts, random writes;
    // 3: ready high except a two-cycle stall on beat 3 during which R3 and R10 are rewritten.
    task automatic dump(input int mode);
        int      exp_idx = 0;
        int      stall3 = 0;
        int      n;
        bit      v_prev = 0;
        bit      hs;
        bit      rdy;
        bit      got_done = 0;
        logic [31:0] h_data = '0;
        logic [4:0]  h_idx = '0;
        logic        h_last = 0;

        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (n = 1; n <= 600 && !got_done; n++) begin
            unique case (mode)
                0: rdy = 1'b1;
                1: rdy = (n % 4 == 1) || (n % 4 == 0);
                2: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = 1'b1;
                    if (v_prev && h_idx == 5'd3 && stall3 < 2) begin
                        rdy = 1'b0;
                        if (stall3 == 0) begin
                            regs[3]  = 32'h12345678;
                            regs[10] = 32'h0BADF00D;
                        end
                        stall3++;
                    end
                end
            endcase
            out_ready = rdy;
            if (mode == 2) begin
                start = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 2) == 0) regs[$urandom_range(0, 31)] = $urandom;
            end
            hs = v_prev && rdy;
            tick();
            if (hs) begin
                exp_idx++;
                chk("valid_drop_after_hs", out_valid, 0);
            end else if (v_prev) begin
                chk("valid_held", out_valid, 1);
                chk("index_stable", out_index, h_idx);
                chk("data_stable", out_data, h_data);
                chk("last_stable", out_last, h_last);
                if (mode == 3 && h_idx == 5'd3) chk("r3_held_old", out_data, 32'hA5A50003);
            end else if (out_valid) begin
                chk("beat_index", out_index, exp_idx);
                chk("beat_data", out_data, regs[exp_idx]);
                chk("beat_last", out_last, exp_idx == 31);
                if (mode == 3 && exp_idx == 10) chk("r10_new", out_data, 32'h0BADF00D);
                if (mode != 2) chk("beat_data_preload", out_data,
                    (mode == 3 && exp_idx == 10) ? 32'h0BADF00D : 32'hA5A50000 + 32'(exp_idx));
                h_idx = out_index;
                h_data = out_data;
                h_last = out_last;
            end
            if (done) begin
                got_done = 1;
                chk("beats_before_done", exp_idx, 32);
                if (mode == 0) chk("done_edge", n, 64);
            end
            chk("busy_during", busy, 1);
            v_prev = out_valid;
        end
        out_ready = 1'b0;
        // A start coinciding with the done pulse must be ignored.
        start = 1'b1;
        if (!got_done) chk("dump_timeout", 0, 1);
        tick();
        start = 1'b0;
        chk("busy_fall", busy, 0);
        chk("done_one_cycle", done, 0);
        tick();
        chk("start_in_done_ignored", busy, 0);
    endtask

    task automatic wait_beat(input logic [4:0] idx, input bit poke, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            out_ready = 1'b1;
            start = poke && ($urandom_range(0, 1) == 1);
            tick();
            if (out_valid && out_index == idx) ok = 1;
        end
        start = 1'b0;
        if (!ok) chk("wait_beat_timeout", idx, 32'hFF);
    endtask

    initial begin
        bit ok;
        preload();
        #12;
        reset = 1'b0;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_index", out_index, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_addr_one", rd_addr1, 5);

        dump(0);
        preload();
        dump(1);
        preload();
        dump(3);

        // Single-register range.
        regs[5] = 32'hDEADBEEF;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        chk("one_valid", out_valid1, 1);
        chk("one_index", out_index1, 5);
        chk("one_data", out_data1, 32'hDEADBEEF);
        chk("one_last", out_last1, 1);
        tick();
        chk("one_valid_drop", out_valid1, 0);
        chk("one_done", done1, 1);
        tick();
        chk("one_done_gone", done1, 0);
        chk("one_busy_fall", busy1, 0);
        ready1 = 1'b0;

        // Abort together with a handshake on beat 7.
        preload();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd7, 1'b0, ok);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_last", out_last, 0);
        chk("abort_rd_addr", rd_addr, 0);
        tick();
        chk("abort_no_done", done, 0);
        chk("abort_stays_idle", busy, 0);
        dump(0);

        // Asynchronous reset in the middle of beat 12, with stray starts while busy.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd12, 1'b1, ok);
        out_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_index", out_index, 0);
        chk("arst_data", out_data, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_done", done, 0);
        #1;
        reset = 1'b0;
        tick();
        chk("arst_no_done", done, 0);
        chk("arst_idle", busy, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            dump(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
